// File: rtl/enc_pkg.sv
// enc_pkg: shared code/one-hot types and the 2-to-4 decode function
package enc_pkg;
  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;
  function automatic onehot_t decode(input code_t c, input logic en);
    return en ? onehot_t'(onehot_t'(1) << c) : '0;
  endfunction
endpackage

// File: rtl/dec_if.sv
// dec_if: stream-side signal bundle for the 2-to-4 decoder, clock and reset as ports
interface dec_if #(parameter int CNT_W = 16) (input logic clk, input logic reset);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       data_in;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       data_out;
  logic [CNT_W-1:0] sym_count;
endinterface

// File: rtl/decoder_fifo.sv
// decoder_fifo: count-tracked circular buffer holding decoded words in push order
module decoder_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/decoder_2to4_stream.sv
// decoder_2to4_stream: decodes 2-bit codes to one-hot words behind a ready/valid FIFO
module decoder_2to4_stream
  import enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       data_in,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [CNT_W-1:0] sym_count
);
  logic full, empty, push, pop;
  // Reset gates both handshakes so no transfer lands on a reset edge
  assign in_ready = !reset && !full;
  assign push = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready && !reset;
  decoder_fifo #(.DEPTH(DEPTH), .W(4)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(decode(code_t'(data_in), in_en)),
    .dout(data_out),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) sym_count <= '0;
    else if (pop) sym_count <= sym_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_decoder_2to4_stream.sv
// tb_decoder_2to4_stream: directed ready/valid checks of the 2-to-4 stream decoder
module tb_decoder_2to4_stream;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  dec_if #(.CNT_W(4)) ifc (.clk(clk), .reset(reset));
  decoder_2to4_stream #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(ifc.in_valid),
    .in_ready(ifc.in_ready),
    .data_in(ifc.data_in),
    .in_en(ifc.in_en),
    .out_valid(ifc.out_valid),
    .out_ready(ifc.out_ready),
    .data_out(ifc.data_out),
    .sym_count(ifc.sym_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] d, input logic e);
    ifc.in_valid = v;
    ifc.data_in = d;
    ifc.in_en = e;
  endtask
  logic [3:0] sweep_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [1:0] sweep_code [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic sweep_en [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  initial begin
    drive(0, 2'b00, 0);
    ifc.out_ready = 0;
    repeat (3) tick;
    chk("rst_in_ready", 32'(ifc.in_ready), 0);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_data_out", 32'(ifc.data_out), 0);
    chk("rst_sym_count", 32'(ifc.sym_count), 0);
    reset = 0;
    #1;
    chk("post_rst_in_ready", 32'(ifc.in_ready), 1);
    // single word, one-cycle latency
    drive(1, 2'b10, 1);
    ifc.out_ready = 1;
    tick;
    drive(0, 2'b00, 0);
    chk("lat_out_valid", 32'(ifc.out_valid), 1);
    chk("lat_data_out", 32'(ifc.data_out), 32'b0100);
    tick;
    chk("lat_drained", 32'(ifc.out_valid), 0);
    chk("lat_sym_count", 32'(ifc.sym_count), 1);
    // code sweep with simultaneous push/pop at occupancy 1
    reset = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, sweep_code[i], sweep_en[i]);
      tick;
      chk($sformatf("sweep_data_%0d", i), 32'(ifc.data_out), 32'(sweep_exp[i]));
      chk($sformatf("sweep_valid_%0d", i), 32'(ifc.out_valid), 1);
      chk($sformatf("sweep_ready_%0d", i), 32'(ifc.in_ready), 1);
    end
    drive(0, 2'b00, 0);
    tick;
    chk("sweep_sym_count", 32'(ifc.sym_count), 5);
    chk("sweep_empty", 32'(ifc.out_valid), 0);
    tick;
    chk("empty_pop_ignored", 32'(ifc.sym_count), 5);
    chk("empty_data_out", 32'(ifc.data_out), 0);
    // backpressure fill to full
    reset = 1;
    tick;
    reset = 0;
    ifc.out_ready = 0;
    drive(1, 2'b00, 1);
    tick;
    drive(1, 2'b01, 1);
    tick;
    chk("full_in_ready", 32'(ifc.in_ready), 0);
    chk("full_head", 32'(ifc.data_out), 32'b0001);
    drive(1, 2'b11, 1);
    tick;
    chk("full_ignored_ready", 32'(ifc.in_ready), 0);
    chk("full_hold_data", 32'(ifc.data_out), 32'b0001);
    chk("full_hold_valid", 32'(ifc.out_valid), 1);
    drive(0, 2'b00, 0);
    ifc.out_ready = 1;
    tick;
    chk("unfull_in_ready", 32'(ifc.in_ready), 1);
    chk("unfull_second", 32'(ifc.data_out), 32'b0010);
    chk("unfull_sym_count", 32'(ifc.sym_count), 1);
    tick;
    chk("unfull_drained", 32'(ifc.out_valid), 0);
    chk("unfull_sym_count2", 32'(ifc.sym_count), 2);
    // reset while full discards buffered words
    ifc.out_ready = 0;
    drive(1, 2'b10, 1);
    tick;
    drive(1, 2'b11, 1);
    tick;
    chk("prefull_in_ready", 32'(ifc.in_ready), 0);
    drive(0, 2'b00, 0);
    ifc.out_ready = 1;
    reset = 1;
    tick;
    chk("midrst_out_valid", 32'(ifc.out_valid), 0);
    chk("midrst_data_out", 32'(ifc.data_out), 0);
    chk("midrst_sym_count", 32'(ifc.sym_count), 0);
    chk("midrst_in_ready", 32'(ifc.in_ready), 0);
    reset = 0;
    tick;
    chk("midrst_no_delivery", 32'(ifc.out_valid), 0);
    chk("midrst_count_hold", 32'(ifc.sym_count), 0);
    // 17 deliveries wrap the 4-bit counter
    drive(1, 2'b01, 1);
    repeat (17) tick;
    chk("wrap_at_16", 32'(ifc.sym_count), 0);
    drive(0, 2'b00, 0);
    tick;
    chk("wrap_at_17", 32'(ifc.sym_count), 1);
    chk("wrap_empty", 32'(ifc.out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_2to4_stream.md
DECODER_2TO4_STREAM -- requirements
Module: decoder_2to4_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the delivered-symbol counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream code valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port data_in  input  2  binary code (the format the team's 4-to-2 encoder produces).
REQ-008 SHALL have port in_en  input  1  code-valid qualifier; 0 means "no active input line".
REQ-009 SHALL have port out_valid  output  1  data_out holds a decoded word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts data_out.
REQ-011 SHALL have port data_out  output  4  one-hot decoded word.
REQ-012 SHALL have port sym_count  output  CNT_W  count of words delivered downstream.

Function
REQ-013 SHALL accept an input when in_valid && in_ready at a rising edge (push).
REQ-014 SHALL decode on push: in_en=1: 00->0001, 01->0010, 10->0100, 11->1000; in_en=0 -> 0000 regardless of data_in.
REQ-015 SHALL store decoded words in a FIFO of DEPTH entries, delivered in push order.
REQ-016 SHALL drive in_ready = !full, combinationally from occupancy only (never from out_ready).
REQ-017 SHALL present the FIFO head on data_out with out_valid = !empty; data_out SHALL be 0000 when empty.
REQ-018 SHALL pop the head when out_valid && out_ready at a rising edge.
REQ-019 Latency: word pushed at edge N into an empty FIFO SHALL appear with out_valid=1 in the cycle after edge N; no same-cycle bypass.
REQ-020 Simultaneous push and pop when neither empty nor full SHALL leave occupancy unchanged and preserve ordering.
REQ-021 Full: in_ready=0; in_valid SHALL be ignored; a pop in that cycle SHALL raise in_ready the next cycle.
REQ-022 Empty: out_ready SHALL be ignored; no pop, sym_count unchanged.
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a count (0..DEPTH), not pointer equality alone.
REQ-024 sym_count SHALL increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
REQ-025 data_out SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While reset=1 at an edge: pointers, occupancy, sym_count SHALL clear to 0; out_valid=0, data_out=0000 the next cycle.
REQ-027 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-028 Reset mid-operation SHALL discard all buffered words; no pop or push SHALL occur on a reset edge.

Structure
REQ-029 Shared package enc_pkg SHALL hold code_t (2-bit), onehot_t (4-bit), and the decode function used by RTL and scoreboard.
REQ-030 FIFO SHALL be a sub-module decoder_fifo (parameterised DEPTH, width 4); decode logic SHALL stay in the top.
REQ-031 Block SHALL be bound to the bench through an interface carrying clk and reset as ports, matching the team's encoder interface style.

Verification
REQ-032 Reset for 3 cycles, then in_valid=1 data_in=10 in_en=1, out_ready=1 -> out_valid=1 data_out=0100 one cycle after accept; sym_count=1.
REQ-033 Sweep codes 00,01,10,11 with in_en=1 then 11 with in_en=0, out_ready=1 -> outputs 0001,0010,0100,1000,0000 in order; sym_count=5.
REQ-034 out_ready=0, push 3 codes with DEPTH=2 -> two accepted, in_ready=0 on third; data_out stable at first word; raise out_ready -> in_ready=1 next cycle, order preserved.
REQ-035 FIFO holding 1 word, push and pop same cycle -> occupancy stays 1, next word follows correctly.
REQ-036 Buffer full, assert reset one cycle -> out_valid=0, data_out=0000, sym_count=0, buffered words never delivered.
REQ-037 CNT_W=4, 17 delivered words -> sym_count wraps 15->0 and reads 1.
